// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and sizing helpers for the arbiter-PUF challenge sequencer.
package puf_pkg;

    localparam int DEFAULT_N = 128;

    // EVAL is kept in the encoding for compatibility with older tooling; the FSM never enters it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LAUNCH = 3'd2,
        EVAL   = 3'd3,
        RELAX  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Width needed to hold every value in 0..max_val (never less than 1 bit).
    function automatic int clog2_cnt(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Challenge/response handshake bundle; PUF_STABILITY_EN adds the vote-count fields.
interface puf_challenge_sequencer_if
    import puf_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int REPEATS = 5
);
    logic         chal_valid;
    logic         chal_ready;
    logic [N-1:0] chal_data;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_bit;
`ifdef PUF_STABILITY_EN
    localparam int CW = clog2_cnt(REPEATS);
    logic [CW-1:0] resp_ones;
    logic          resp_unstable;
`endif

    modport master (
        output chal_valid, chal_data, resp_ready,
`ifdef PUF_STABILITY_EN
        input  resp_ones, resp_unstable,
`endif
        input  chal_ready, resp_valid, resp_bit
    );

    modport slave (
        input  chal_valid, chal_data, resp_ready,
`ifdef PUF_STABILITY_EN
        output resp_ones, resp_unstable,
`endif
        output chal_ready, resp_valid, resp_bit
    );
endinterface

// File: rtl/puf_challenge_sequencer_sync.sv
// Two-flop synchroniser for the asynchronous SR-latch response of the chain.
module puf_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);
    logic meta;

    // NOTE: non-blocking assignments make both flops sample the old values, forming a true 2-stage chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: settle, REPEATS launch/relax races, majority vote.
// Optional macro PUF_STABILITY_EN exposes the raw vote count and an instability flag.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int SETTLE_CYC = 4,
    parameter int EVAL_CYC   = 8,
    parameter int RELAX_CYC  = 4,
    parameter int REPEATS    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    puf_challenge_sequencer_if.slave bus,
    output logic                  busy,
    output logic [N-1:0]          puf_control,
    output logic                  puf_launch,
    input  logic                  puf_out
);
    localparam int CW        = clog2_cnt(REPEATS);
    localparam int PHASE_MAX = (SETTLE_CYC > EVAL_CYC) ?
                               ((SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC) :
                               ((EVAL_CYC > RELAX_CYC) ? EVAL_CYC : RELAX_CYC);
    localparam int PW        = clog2_cnt(PHASE_MAX - 1);

    if (REPEATS < 1 || (REPEATS % 2) == 0) begin : g_bad_repeats
        $error("puf_challenge_sequencer: REPEATS must be odd and >= 1");
    end
    if (SETTLE_CYC < 1 || EVAL_CYC < 3 || RELAX_CYC < 1) begin : g_bad_timing
        $error("puf_challenge_sequencer: SETTLE_CYC>=1, EVAL_CYC>=3, RELAX_CYC>=1 required");
    end

    state_t        state;
    logic [PW-1:0] phase;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] rep_cnt;
    logic          puf_sync;

    puf_resp_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (puf_out),
        .sync_out (puf_sync)
    );

    // NOTE: gating with rst keeps chal_ready low while reset is held yet high in the first cycle after it.
    assign bus.chal_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            phase          <= '0;
            ones_cnt       <= '0;
            rep_cnt        <= '0;
            busy           <= 1'b0;
            puf_control    <= '0;
            puf_launch     <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_bit   <= 1'b0;
`ifdef PUF_STABILITY_EN
            bus.resp_ones     <= '0;
            bus.resp_unstable <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.chal_valid) begin
                        puf_control <= bus.chal_data;
                        ones_cnt    <= '0;
                        rep_cnt     <= '0;
                        phase       <= '0;
                        busy        <= 1'b1;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (phase == PW'(SETTLE_CYC - 1)) begin
                        phase      <= '0;
                        puf_launch <= 1'b1;
                        state      <= LAUNCH;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LAUNCH: begin
                    if (phase == PW'(EVAL_CYC - 1)) begin
                        ones_cnt   <= ones_cnt + CW'(puf_sync);
                        phase      <= '0;
                        puf_launch <= 1'b0;
                        state      <= RELAX;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                RELAX: begin
                    if (phase == PW'(RELAX_CYC - 1)) begin
                        phase   <= '0;
                        rep_cnt <= rep_cnt + 1'b1;
                        if (rep_cnt == CW'(REPEATS - 1)) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_bit   <= (ones_cnt > CW'(REPEATS / 2));
`ifdef PUF_STABILITY_EN
                            bus.resp_ones     <= ones_cnt;
                            bus.resp_unstable <= (ones_cnt != '0) && (ones_cnt != CW'(REPEATS));
`endif
                            state <= DONE;
                        end else begin
                            puf_launch <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
